// File: rtl/bus_interconnect_if.sv
// Bundle of master request/response and shared slave bus signals.
// Modport master is the interconnect's view; slave is the environment's.
interface bus_interconnect_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
);
  logic [NUM_MASTERS-1:0]        m_req_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0]        m_rw_i;
  logic [NUM_MASTERS-1:0]        m_gnt_o;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [DATA_W-1:0]             m_rdata_o;
  logic [NUM_SLAVES-1:0]         s_sel_o;
  logic [ADDR_W-1:0]             s_addr_o;
  logic [DATA_W-1:0]             s_wdata_o;
  logic                          s_rw_o;
  logic                          s_strobe_o;
  logic [NUM_SLAVES-1:0]         s_ready_i;
  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i;

  modport master (
    input  m_req_i, m_addr_i, m_wdata_i, m_rw_i,
    input  s_ready_i, s_rdata_i,
    output m_gnt_o, m_ack_o, m_err_o, m_rdata_o,
    output s_sel_o, s_addr_o, s_wdata_o, s_rw_o,
    output s_strobe_o
  );

  modport slave (
    output m_req_i, m_addr_i, m_wdata_i, m_rw_i,
    output s_ready_i, s_rdata_i,
    input  m_gnt_o, m_ack_o, m_err_o, m_rdata_o,
    input  s_sel_o, s_addr_o, s_wdata_o, s_rw_o,
    input  s_strobe_o
  );
endinterface

// File: rtl/bus_interconnect.sv
// Round-robin N-master to M-slave single-outstanding bus interconnect
// with address decode, wait-state timeout and error reporting.
module bus_interconnect #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {16'h4000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE =
    {16'h1000, 16'h0100, 16'h0020, 16'h1000},
  parameter int CLK_MAX_TIMEOUT = 10
) (
  input  logic               clk,
  input  logic               rst,
  bus_interconnect_if.master bus
);

  localparam int MW =
    (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW =
    (CLK_MAX_TIMEOUT > 0) ? $clog2(CLK_MAX_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LAST =
    CW'((CLK_MAX_TIMEOUT > 0) ? CLK_MAX_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] C_MAX = CW'(CLK_MAX_TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [NUM_MASTERS-1:0] r_err;
  logic [MW-1:0]          r_last;
  logic [MW-1:0]          r_cur;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_rw;
  logic [DATA_W-1:0]      r_rdata;
  logic [NUM_SLAVES-1:0]  r_sel;
  logic [SW-1:0]          r_sidx;
  logic                   r_strobe;
  logic [CW-1:0]          r_cnt;

  logic                   w_found;
  logic [MW-1:0]          w_win;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W-1:0]      w_wdata;
  logic                   w_rw;
  logic                   w_hit;
  logic [SW-1:0]          w_sidx;
  logic                   w_rdy;
  logic [DATA_W-1:0]      w_srd;

  // Walk a doubled index range so the search starts just past r_last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < 2 * NUM_MASTERS; i++) begin
      if (!w_found &&
          i > int'(r_last) &&
          i <= int'(r_last) + NUM_MASTERS &&
          bus.m_req_i[i % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_win   = MW'(i % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_rw    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win == MW'(i)) begin
        w_addr  = bus.m_addr_i[i*ADDR_W +: ADDR_W];
        w_wdata = bus.m_wdata_i[i*DATA_W +: DATA_W];
        w_rw    = bus.m_rw_i[i];
      end
    end
  end

  // Descending scan: the lowest matching window is assigned last.
  always_comb begin
    w_hit  = 1'b0;
    w_sidx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ({1'b0, r_addr} >=
            {1'b0, SLAVE_BASE[k*ADDR_W +: ADDR_W]} &&
          {1'b0, r_addr} <
            {1'b0, SLAVE_BASE[k*ADDR_W +: ADDR_W]} +
            {1'b0, SLAVE_SIZE[k*ADDR_W +: ADDR_W]}) begin
        w_hit  = 1'b1;
        w_sidx = SW'(k);
      end
    end
  end

  always_comb begin
    w_rdy = 1'b0;
    w_srd = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_sidx == SW'(k)) begin
        w_rdy = bus.s_ready_i[k];
        w_srd = bus.s_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_last   <= MW'(NUM_MASTERS - 1);
      r_cur    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rw     <= 1'b0;
      r_rdata  <= '0;
      r_sel    <= '0;
      r_sidx   <= '0;
      r_strobe <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= NUM_MASTERS'(1) << w_win;
            r_cur   <= w_win;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rw    <= w_rw;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_hit) begin
            r_sel    <= NUM_SLAVES'(1) << w_sidx;
            r_sidx   <= w_sidx;
            r_cnt    <= '0;
            r_strobe <= 1'b1;
            r_state  <= S_WAIT;
          end else begin
            r_err   <= r_gnt;
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_rdy) begin
            if (!r_rw) begin
              r_rdata <= w_srd;
            end
            r_ack    <= r_gnt;
            r_strobe <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt >= C_LAST) begin
            r_err    <= r_gnt;
            r_strobe <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ack   <= '0;
          r_err   <= '0;
          r_gnt   <= '0;
          r_sel   <= '0;
          r_last  <= r_cur;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_gnt_o    = r_gnt;
  assign bus.m_ack_o    = r_ack;
  assign bus.m_err_o    = r_err;
  assign bus.m_rdata_o  = r_rdata;
  assign bus.s_sel_o    = r_sel;
  assign bus.s_addr_o   = r_addr;
  assign bus.s_wdata_o  = r_wdata;
  assign bus.s_rw_o     = r_rw;
  assign bus.s_strobe_o = r_strobe;

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: directed transactions,
// a slave responder model and a decoupled completion monitor.
module tb_bus_interconnect;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_interconnect_if #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ADDR_W(AW), .DATA_W(DW)
  ) bif ();

  bus_interconnect #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] mst;
    bit            err;
    logic [DW-1:0] rdata;
    logic [NS-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            strb;
    int            lat;
    int            t0;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_n = 1;
  int scnt = 0;
  int strb = 0;
  bit prev_pulse = 0;
  logic [NS-1:0] noise = '0;
  logic [DW-1:0] model_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave responder: ready in the wait_n-th strobe cycle (0 = never).
  always @(negedge clk) begin
    if (bif.s_strobe_o) scnt++;
    else scnt = 0;
    bif.s_ready_i = noise |
      ((wait_n > 0 && scnt == wait_n) ? bif.s_sel_o : '0);
  end

  always @(negedge clk) begin
    if (rst) begin
      strb = 0;
      prev_pulse = 0;
    end else begin
      if (bif.s_strobe_o) strb++;
      if ((bif.m_ack_o | bif.m_err_o) != '0) begin
        chk("pulse_width", 32'(prev_pulse), 0);
        if (q.size() == 0) begin
          chk("unexpected_pulse",
              32'(bif.m_ack_o | bif.m_err_o), 0);
        end else begin
          me = q.pop_front();
          chk("ack", 32'(bif.m_ack_o),
              me.err ? 32'(0) : 32'(me.mst));
          chk("err", 32'(bif.m_err_o),
              me.err ? 32'(me.mst) : 32'(0));
          chk("gnt", 32'(bif.m_gnt_o), 32'(me.mst));
          chk("sel", 32'(bif.s_sel_o), 32'(me.sel));
          chk("s_addr", 32'(bif.s_addr_o), 32'(me.addr));
          chk("s_wdata", 32'(bif.s_wdata_o), 32'(me.wdata));
          chk("rdata", 32'(bif.m_rdata_o), 32'(me.rdata));
          chk("strobe_cycles", strb, me.strb);
          if (me.lat >= 0) chk("latency", cyc - me.t0, me.lat);
        end
        strb = 0;
        prev_pulse = 1;
      end else begin
        prev_pulse = 0;
      end
    end
  end

  task automatic wait_empty(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_txn(input int m, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit rw,
                        input int wn, input bit err,
                        input logic [NS-1:0] sel, input int sn,
                        input int lat, input logic [DW-1:0] rd,
                        input int intr);
    exp_t x;
    int n = 0;
    @(negedge clk);
    wait_n = wn;
    bif.m_addr_i[m*AW +: AW] = a;
    bif.m_wdata_i[m*DW +: DW] = wd;
    bif.m_rw_i[m] = rw;
    if (!rw && !err) model_rd = rd;
    x.mst = NM'(1) << m;
    x.err = err;
    x.rdata = model_rd;
    x.sel = sel;
    x.addr = a;
    x.wdata = wd;
    x.strb = sn;
    x.lat = lat;
    x.t0 = cyc;
    q.push_back(x);
    bif.m_req_i[m] = 1'b1;
    while (!bif.m_gnt_o[m] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("grant_timeout", 0, 1);
    bif.m_req_i[m] = 1'b0;
    if (intr >= 0) begin
      bif.m_req_i[intr] = 1'b1;
      repeat (2) @(negedge clk);
      bif.m_req_i[intr] = 1'b0;
    end
    wait_empty(40);
  endtask

  initial begin
    exp_t x;
    int n;
    bif.m_req_i = '0;
    bif.m_addr_i = '0;
    bif.m_wdata_i = '0;
    bif.m_rw_i = '0;
    bif.s_ready_i = '0;
    for (int k = 0; k < NS; k++)
      bif.s_rdata_i[k*DW +: DW] = 16'hA000 + 16'(k);
    bif.s_rdata_i[2*DW +: DW] = 16'hBEEF;

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bif.m_gnt_o), 0);
    chk("rst_ack", 32'(bif.m_ack_o), 0);
    chk("rst_err", 32'(bif.m_err_o), 0);
    chk("rst_rdata", 32'(bif.m_rdata_o), 0);
    chk("rst_sel", 32'(bif.s_sel_o), 0);
    chk("rst_strobe", 32'(bif.s_strobe_o), 0);
    chk("rst_s_addr", 32'(bif.s_addr_o), 0);
    rst = 1'b0;

    do_txn(0, 16'h101E, 16'd99, 1, 1, 0, 4'b0010, 1, 3, 0, -1);
    noise = 4'b0001;
    do_txn(2, 16'h2005, 16'h0, 0, 4, 0, 4'b0100, 4, 6,
           16'hBEEF, 1);
    noise = '0;
    do_txn(3, 16'h0010, 16'h1234, 1, 2, 0, 4'b0001, 2, 4, 0, -1);
    do_txn(1, 16'h8000, 16'h5555, 0, 1, 1, 4'b0000, 0, 2, 0, -1);
    do_txn(0, 16'h4FFF, 16'h0, 0, 0, 1, 4'b1000, 10, 12, 0, -1);
    @(negedge clk);
    chk("gnt_released", 32'(bif.m_gnt_o), 0);
    chk("sel_released", 32'(bif.s_sel_o), 0);
    do_txn(1, 16'h0FFF, 16'h0, 0, 1, 0, 4'b0001, 1, 3,
           16'hA000, -1);
    do_txn(2, 16'h101F, 16'h0, 0, 1, 0, 4'b0010, 1, 3,
           16'hA001, -1);
    do_txn(3, 16'h1020, 16'h0, 0, 1, 1, 4'b0000, 0, 2, 0, -1);

    @(negedge clk);
    wait_n = 0;
    bif.m_addr_i[1*AW +: AW] = 16'h2000;
    bif.m_rw_i[1] = 1'b0;
    bif.m_req_i[1] = 1'b1;
    n = 0;
    while (scnt < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("wait_entry_timeout", 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(bif.m_gnt_o), 0);
    chk("mid_rst_ack", 32'(bif.m_ack_o), 0);
    chk("mid_rst_err", 32'(bif.m_err_o), 0);
    chk("mid_rst_sel", 32'(bif.s_sel_o), 0);
    chk("mid_rst_strobe", 32'(bif.s_strobe_o), 0);
    chk("mid_rst_rdata", 32'(bif.m_rdata_o), 0);
    bif.m_req_i = '0;
    model_rd = '0;

    wait_n = 1;
    for (int k = 0; k < NM; k++) begin
      bif.m_addr_i[k*AW +: AW] = 16'h4000 + 16'(k);
      bif.m_wdata_i[k*DW +: DW] = 16'h0011 * 16'(k) + 16'h1;
      bif.m_rw_i[k] = 1'b1;
    end
    bif.m_req_i = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      x.mst = NM'(1) << (j % NM);
      x.err = 0;
      x.rdata = model_rd;
      x.sel = 4'b1000;
      x.addr = 16'h4000 + 16'(j % NM);
      x.wdata = 16'h0011 * 16'(j % NM) + 16'h1;
      x.strb = 1;
      x.lat = (j == 0) ? 3 : -1;
      x.t0 = cyc;
      q.push_back(x);
    end
    wait_empty(80);
    bif.m_req_i = '0;

    repeat (6) @(negedge clk);
    chk("idle_gnt", 32'(bif.m_gnt_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
